// File: rtl/bcd_a_bin_2dig_pkg.sv
// Shared constants and state encoding for the two-digit BCD to binary converter.
package bcd_a_bin_2dig_pkg;

    localparam int N_DEF       = 6;
    localparam int MAX_VAL_DEF = 59;

    localparam logic [3:0] BCD_LIM = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_a_bin_2dig_ajuste_nib.sv
// Per-nibble correction for the reverse double-dabble step:
// a nibble that reached 8 or more after the shift gets 3 taken off.
module bcd_ajuste_nib (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    assign nib_out = (nib_in >= 4'd8) ? nib_in - 4'd3 : nib_in;

endmodule

// File: rtl/bcd_a_bin_2dig.sv
// Two-digit BCD to binary converter, one shift per cycle
// (reverse double-dabble), with range check against MAX_VAL.
module bcd_a_bin_2dig
    import bcd_a_bin_2dig_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int MAX_VAL = MAX_VAL_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   digit1,
    input  logic [3:0]   digit0,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [N-1:0] count_bin
);

    localparam logic [N-1:0] MAX_V = N'(MAX_VAL);
    localparam logic [2:0]   LAST  = 3'(N - 1);

    state_t state_q;
    state_t state_d;

    logic [7:0]   bcd_q;
    logic [7:0]   bcd_sh;
    logic [7:0]   bcd_adj;
    logic [N-1:0] res_q;
    logic [N-1:0] res_sh;
    logic [N-1:0] cnt_q;
    logic [2:0]   step_q;
    logic         err_q;
    logic         bad_dig;
    logic         last;
    logic         ovf;

    assign bcd_sh = {1'b0, bcd_q[7:1]};
    assign res_sh = {bcd_q[0], res_q[N-1:1]};

    bcd_ajuste_nib u_nib_hi (
        .nib_in  (bcd_sh[7:4]),
        .nib_out (bcd_adj[7:4])
    );

    bcd_ajuste_nib u_nib_lo (
        .nib_in  (bcd_sh[3:0]),
        .nib_out (bcd_adj[3:0])
    );

    assign bad_dig = (bcd_q[7:4] > BCD_LIM) || (bcd_q[3:0] > BCD_LIM);
    assign last    = (step_q == LAST);
    // Bits left in the BCD register after N shifts are value bits above 2^N.
    assign ovf     = (bcd_adj != 8'd0) || (res_sh > MAX_V);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = CHECK;
            end
            CHECK: state_d = bad_dig ? DONE : SHIFT;
            SHIFT: if (last) state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q  <= 8'd0;
            res_q  <= '0;
            step_q <= 3'd0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bcd_q  <= {digit1, digit0};
                        res_q  <= '0;
                        step_q <= 3'd0;
                    end
                end
                CHECK: begin
                    if (bad_dig) err_q <= 1'b1;
                end
                SHIFT: begin
                    bcd_q  <= bcd_adj;
                    res_q  <= res_sh;
                    step_q <= step_q + 3'd1;
                    if (last) begin
                        if (ovf) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q <= 1'b0;
                            cnt_q <= res_sh;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign error     = err_q;
    assign count_bin = cnt_q;

endmodule

// File: tb/tb_bcd_a_bin_2dig.sv
// Bench for bcd_a_bin_2dig: vector table, expectation queue,
// plus hand sequences for held start and mid-conversion reset.
module tb_bcd_a_bin_2dig;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] digit1 = 4'd0;
    logic [3:0] digit0 = 4'd0;
    logic       busy;
    logic       done;
    logic       error;
    logic [5:0] count_bin;

    bcd_a_bin_2dig dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .digit1    (digit1),
        .digit0    (digit0),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .count_bin (count_bin)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] cnt;
        logic       err;
        int         lat;
    } exp_t;

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d0;
        exp_t       e;
    } vec_t;

    vec_t vt[13];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_chk = 0;

    task automatic chk1(input string nm, input logic act, input logic req);
        n_chk++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", nm, act, req);
        end
    endtask

    task automatic chk6(input string nm, input logic [5:0] act, input logic [5:0] req);
        n_chk++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic chki(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    // Call at a falling edge; start is sampled at the next rising edge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input exp_t e, input bit hold);
        digit1 = a;
        digit0 = b;
        start  = 1'b1;
        sb.push_back(e);
        n_vec++;
        @(posedge clk);
        #1;
        chk1("busy_after_start", busy, 1'b1);
        chk1("no_early_done", done, 1'b0);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic collect(input int chg_at);
        int   cyc;
        bit   seen;
        exp_t e;
        seen = 0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1;
                break;
            end
            chk1("busy_during", busy, 1'b1);
            if (cyc == chg_at) begin
                digit1 = 4'd9;
                digit0 = 4'd9;
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            n_chk++;
            n_bad++;
            $display("FAIL done_timeout: got none, want done at cycle %0d", e.lat);
        end else begin
            chki("latency", cyc, e.lat);
            chk6("count_bin", count_bin, e.cnt);
            chk1("error", error, e.err);
            chk1("busy_in_done", busy, 1'b1);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk1("done_one_cycle", done, 1'b0);
        chk1("busy_idle", busy, 1'b0);
    endtask

    initial begin
        int ndone;

        vt[0]  = '{4'd5, 4'd9,  '{6'd59, 1'b0, 7}};
        vt[1]  = '{4'd0, 4'd0,  '{6'd0,  1'b0, 7}};
        vt[2]  = '{4'd2, 4'd3,  '{6'd23, 1'b0, 7}};
        vt[3]  = '{4'd3, 4'hA,  '{6'd23, 1'b1, 1}};
        vt[4]  = '{4'd6, 4'd5,  '{6'd23, 1'b1, 7}};
        vt[5]  = '{4'd1, 4'd7,  '{6'd17, 1'b0, 7}};
        vt[6]  = '{4'd9, 4'd9,  '{6'd17, 1'b1, 7}};
        vt[7]  = '{4'd0, 4'd9,  '{6'd9,  1'b0, 7}};
        vt[8]  = '{4'd5, 4'd0,  '{6'd50, 1'b0, 7}};
        vt[9]  = '{4'hF, 4'd0,  '{6'd50, 1'b1, 1}};
        vt[10] = '{4'd1, 4'd0,  '{6'd10, 1'b0, 7}};
        vt[11] = '{4'd6, 4'd0,  '{6'd10, 1'b1, 7}};
        vt[12] = '{4'd4, 4'd9,  '{6'd49, 1'b0, 7}};

        #12;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk6("rst_count", count_bin, 6'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vt[i]) begin
            @(negedge clk);
            issue(vt[i].d1, vt[i].d0, vt[i].e, 1'b0);
            collect(-1);
        end

        // start held high, digits changed mid-conversion
        @(negedge clk);
        issue(4'd3, 4'd8, '{6'd38, 1'b0, 7}, 1'b1);
        collect(3);
        ndone = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chki("extra_done", ndone, 0);

        // reset during third SHIFT cycle
        @(negedge clk);
        digit1 = 4'd2;
        digit0 = 4'd5;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk1("abort_error", error, 1'b0);
        chk6("abort_count", count_bin, 6'd0);
        ndone = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chki("abort_no_done", ndone, 0);
        @(negedge clk);
        reset = 1'b1;
        issue(4'd4, 4'd2, '{6'd42, 1'b0, 7}, 1'b0);
        collect(-1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
